// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl: records a stimulus symbol sequence and replays it into a controlled 3-bit FSM, then checks its final state
module fsm_seq_ctrl #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [1:0] wr_sym,
  input  logic       clr,
  input  logic       start,
  input  logic [2:0] exp_st,
  input  logic [2:0] fsm_st,
  output logic [1:0] a_out,
  output logic       fsm_rst_n,
  output logic       busy,
  output logic       done,
  output logic       match,
  output logic [5:0] count,
  output logic       full,
  output logic       wr_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, CLR, RUN, CHECK} state_t;
  state_t state, next;
  logic [1:0] mem [DEPTH];
  logic [5:0] rd_idx;
  logic idle, wr_ok;
  assign idle  = state == IDLE;
  assign full  = count == 6'(DEPTH);
  assign wr_ok = idle & wr_en & ~clr & ~start & ~full;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  // next state: a run is CLR, then count RUN cycles, then a single CHECK
  always_comb
    next = state == IDLE ? (start ? CLR : IDLE) :
           state == CLR  ? (count != 6'd0 ? RUN : CHECK) :
           state == RUN  ? (rd_idx + 6'd1 == count ? CHECK : RUN) : IDLE;
  // state-decoded outputs; a_out is only non-zero while replaying
  always_comb begin
    busy  = ~idle;
    done  = state == CHECK;
    a_out = state == RUN ? mem[rd_idx[AW-1:0]] : 2'b00;
  end
  // control registers: controlled-FSM reset, read index, count, compare result, sticky write error
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fsm_rst_n <= 1'b0;
      rd_idx    <= '0;
      count     <= '0;
      match     <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      fsm_rst_n <= next != CLR;
      rd_idx    <= state == RUN ? rd_idx + 6'd1 : 6'd0;
      if (idle && clr) begin
        count  <= '0;
        match  <= 1'b0;
        wr_err <= 1'b0;
      end else begin
        if (wr_ok) count <= count + 6'd1;
        if (wr_en && !wr_ok) wr_err <= 1'b1;
        if (done) match <= fsm_st == exp_st;
      end
    end
  // symbol storage, appended in write order
  always_ff @(posedge clk)
    if (wr_ok) mem[count[AW-1:0]] <= wr_sym;
endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// tb_fsm_seq_ctrl: scoreboard bench driving fsm_seq_ctrl against a small controlled FSM
module tb_fsm_seq_ctrl;
  logic       clk = 0, reset = 0, wr_en = 0, clr = 0, start = 0;
  logic [1:0] wr_sym = 0, a_out;
  logic [2:0] exp_st = 0, fsm_st;
  logic       fsm_rst_n, busy, done, match, full, wr_err;
  logic [5:0] count;
  int n_cmp = 0, n_bad = 0;
  logic [1:0] buf_q[$];
  logic [1:0] exp_q[$];
  fsm_seq_ctrl #(.DEPTH(16)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sym(wr_sym), .clr(clr), .start(start),
    .exp_st(exp_st), .fsm_st(fsm_st), .a_out(a_out), .fsm_rst_n(fsm_rst_n), .busy(busy),
    .done(done), .match(match), .count(count), .full(full), .wr_err(wr_err)
  );
  always #5 clk = ~clk;
  // controlled FSM: trace 1,2,7,1,2,7,1,2,4 for input 1,1,2,2,1,2,0,3,3
  function automatic logic [2:0] nxt(input logic [2:0] s, input logic [1:0] a);
    case ({s, a})
      {3'd0, 2'd1}: return 3'd1;
      {3'd1, 2'd1}: return 3'd2;
      {3'd1, 2'd3}: return 3'd2;
      {3'd2, 2'd2}: return 3'd7;
      {3'd2, 2'd3}: return 3'd4;
      {3'd7, 2'd2}: return 3'd1;
      {3'd7, 2'd0}: return 3'd1;
      default:      return s;
    endcase
  endfunction
  always @(posedge clk or negedge fsm_rst_n)
    if (!fsm_rst_n) fsm_st <= 3'd0;
    else fsm_st <= nxt(fsm_st, a_out);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // replay monitor: every RUN cycle must present the next queued symbol
  always @(negedge clk)
    if (!reset && busy && fsm_rst_n && !done) begin
      if (exp_q.size() == 0) chk("a_extra", 1, 0);
      else chk("a_out", a_out, exp_q.pop_front());
    end
  task automatic wr(input logic [1:0] s);
    @(negedge clk) wr_en = 1; wr_sym = s;
    @(negedge clk) wr_en = 0;
    if (buf_q.size() < 16) buf_q.push_back(s);
  endtask
  task automatic do_clr();
    @(negedge clk) clr = 1;
    @(negedge clk) clr = 0;
    buf_q.delete();
  endtask
  task automatic load9();
    logic [1:0] seq [9] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd2, 2'd0, 2'd3, 2'd3};
    foreach (seq[i]) wr(seq[i]);
  endtask
  // launches a run, optionally pulsing start+wr_en at cycle inj, and checks latency/result
  task automatic run(input logic [2:0] e, input int inj);
    logic [2:0] st = 3'd0;
    int n = buf_q.size();
    int c = 0;
    foreach (buf_q[i]) begin
      exp_q.push_back(buf_q[i]);
      st = nxt(st, buf_q[i]);
    end
    exp_st = e;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    while (!done && c < 60) begin
      if (c == inj) begin start = 1; wr_en = 1; wr_sym = 2'd2; end
      @(negedge clk);
      start = 0; wr_en = 0;
      c++;
    end
    chk("done_lat", c, n + 1);
    chk("fsm_end", fsm_st, st);
    chk("q_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_end", busy, 0);
    chk("match", match, st == e);
    exp_q.delete();
  endtask
  initial begin
    #1 reset = 1;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_match", match, 0);
    chk("rst_done", done, 0);
    chk("rst_a_out", a_out, 0);
    chk("rst_fsm_rst_n", fsm_rst_n, 0);
    @(negedge clk) reset = 0;
    @(posedge clk) #1;
    chk("rel_fsm_rst_n", fsm_rst_n, 1);
    load9();
    chk("count9", count, 9);
    chk("wr_err0", wr_err, 0);
    run(3'd4, -1);
    run(3'd3, -1);
    run(3'd3, -1);
    run(3'd4, 3);
    chk("coll_wr_err", wr_err, 1);
    chk("coll_count", count, 9);
    do_clr();
    chk("clr_count", count, 0);
    chk("clr_wr_err", wr_err, 0);
    chk("clr_match", match, 0);
    @(negedge clk) clr = 1; wr_en = 1; wr_sym = 2'd3;
    @(negedge clk) clr = 0; wr_en = 0;
    chk("clrwr_count", count, 0);
    chk("clrwr_wr_err", wr_err, 0);
    run(3'd0, -1);
    for (int i = 0; i < 17; i++) wr(2'(i));
    chk("full", full, 1);
    chk("full_count", count, 16);
    chk("full_wr_err", wr_err, 1);
    run(3'd0, -1);
    do_clr();
    chk("clr2_count", count, 0);
    chk("clr2_full", full, 0);
    chk("clr2_wr_err", wr_err, 0);
    load9();
    run(3'd4, -1);
    begin
      int k = 0;
      int seen = 0;
      foreach (buf_q[i]) exp_q.push_back(buf_q[i]);
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
      while (exp_q.size() > 5 && k < 50) begin @(negedge clk); k++; end
      chk("pre_rst_wait", k < 50, 1);
      @(posedge clk) #2 reset = 1;
      exp_q.delete();
      #1;
      chk("mr_busy", busy, 0);
      chk("mr_a_out", a_out, 0);
      chk("mr_fsm_rst_n", fsm_rst_n, 0);
      chk("mr_count", count, 0);
      chk("mr_done", done, 0);
      chk("mr_match", match, 0);
      chk("mr_wr_err", wr_err, 0);
      chk("mr_full", full, 0);
      chk("mr_fsm_st", fsm_st, 0);
      @(negedge clk);
      @(negedge clk) reset = 0;
      chk("mr_hold_rst_n", fsm_rst_n, 0);
      @(posedge clk) #1;
      chk("mr_rel_rst_n", fsm_rst_n, 1);
      repeat (15) @(negedge clk) seen |= int'(done);
      chk("mr_no_done", seen, 0);
      chk("mr_count2", count, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
